// File: rtl/pp_pipeline_accel_fifo_to_axis.sv
// Drains rows x cols words from a show-ahead ap_fifo and emits them as an AXI4-Stream video master.
// Optional starvation counter enabled by defining PP_FIFO2AXIS_UNDERRUN_CNT_EN.
module pp_pipeline_accel_fifo_to_axis #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cols,
    input  logic [DIM_WIDTH-1:0]  rows,
    output logic                  busy,
    output logic                  done,
    input  logic                  if_empty_n,
    output logic                  if_read,
    input  logic [DATA_WIDTH-1:0] if_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic [31:0]           underrun_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    localparam logic [DIM_WIDTH-1:0] DimOne = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q;
    logic [DIM_WIDTH-1:0]  cols_q, rows_q;
    logic [DIM_WIDTH-1:0]  col_cnt_q, row_cnt_q;

    // Two-entry output buffer: head drives the stream, tail holds the word popped ahead.
    logic [DATA_WIDTH-1:0] head_data_q, tail_data_q;
    logic                  head_user_q, tail_user_q;
    logic                  head_last_q, tail_last_q;
    logic                  head_vld_q, tail_vld_q;

    logic                  drain, buf_room, pop;
    logic                  col_last, row_last, new_user;

    always_comb begin
        drain    = head_vld_q & m_axis_tready;
        buf_room = ~tail_vld_q | drain;
        pop      = reset_n & (state_q == StRun) & if_empty_n & buf_room;
        col_last = (col_cnt_q == cols_q - DimOne);
        row_last = (row_cnt_q == rows_q - DimOne);
        new_user = (col_cnt_q == '0) && (row_cnt_q == '0);
    end

    assign if_read       = pop;
    assign busy          = (state_q == StRun) || (state_q == StFlush);
    assign done          = (state_q == StDone);
    assign m_axis_tdata  = head_data_q;
    assign m_axis_tvalid = head_vld_q;
    assign m_axis_tuser  = head_user_q;
    assign m_axis_tlast  = head_last_q;

`ifdef PP_FIFO2AXIS_UNDERRUN_CNT_EN
    logic [31:0] underrun_q;
    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cols_q      <= '0;
            rows_q      <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            head_data_q <= '0;
            head_user_q <= 1'b0;
            head_last_q <= 1'b0;
            head_vld_q  <= 1'b0;
            tail_data_q <= '0;
            tail_user_q <= 1'b0;
            tail_last_q <= 1'b0;
            tail_vld_q  <= 1'b0;
`ifdef PP_FIFO2AXIS_UNDERRUN_CNT_EN
            underrun_q  <= '0;
`endif
        end else begin
            // Buffer: drain shifts tail into head, a pop fills the first free slot.
            if (drain) begin
                if (tail_vld_q) begin
                    head_data_q <= tail_data_q;
                    head_user_q <= tail_user_q;
                    head_last_q <= tail_last_q;
                    if (pop) begin
                        tail_data_q <= if_dout;
                        tail_user_q <= new_user;
                        tail_last_q <= col_last;
                    end else begin
                        tail_vld_q <= 1'b0;
                    end
                end else if (pop) begin
                    head_data_q <= if_dout;
                    head_user_q <= new_user;
                    head_last_q <= col_last;
                end else begin
                    head_vld_q <= 1'b0;
                end
            end else if (pop) begin
                if (head_vld_q) begin
                    tail_data_q <= if_dout;
                    tail_user_q <= new_user;
                    tail_last_q <= col_last;
                    tail_vld_q  <= 1'b1;
                end else begin
                    head_data_q <= if_dout;
                    head_user_q <= new_user;
                    head_last_q <= col_last;
                    head_vld_q  <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cols_q    <= cols;
                        rows_q    <= rows;
                        col_cnt_q <= '0;
                        row_cnt_q <= '0;
`ifdef PP_FIFO2AXIS_UNDERRUN_CNT_EN
                        underrun_q <= '0;
`endif
                        state_q   <= ((cols == '0) || (rows == '0)) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (pop) begin
                        if (col_last) begin
                            col_cnt_q <= '0;
                            row_cnt_q <= row_cnt_q + DimOne;
                        end else begin
                            col_cnt_q <= col_cnt_q + DimOne;
                        end
                        if (col_last && row_last) begin
                            state_q <= StFlush;
                        end
                    end
`ifdef PP_FIFO2AXIS_UNDERRUN_CNT_EN
                    if (!if_empty_n && !tail_vld_q && (underrun_q != 32'hFFFF_FFFF)) begin
                        underrun_q <= underrun_q + 32'd1;
                    end
`endif
                end
                StFlush: begin
                    if (!head_vld_q || (drain && !tail_vld_q)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_to_axis.sv
// Directed bench for pp_pipeline_accel_fifo_to_axis with a show-ahead FIFO model and a stream monitor.
module tb_pp_pipeline_accel_fifo_to_axis;

    localparam int DW = 32;
    localparam int MW = 16;
`ifdef PP_FIFO2AXIS_UNDERRUN_CNT_EN
    localparam int UndExp = 5;
`else
    localparam int UndExp = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [MW-1:0] cols = '0;
    logic [MW-1:0] rows = '0;
    logic          busy, done;
    logic          if_empty_n, if_read;
    logic [DW-1:0] if_dout;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [31:0]   underrun_cnt;

    int checks = 0;
    int errors = 0;

    pp_pipeline_accel_fifo_to_axis #(.DATA_WIDTH(DW), .DIM_WIDTH(MW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .cols          (cols),
        .rows          (rows),
        .busy          (busy),
        .done          (done),
        .if_empty_n    (if_empty_n),
        .if_read       (if_read),
        .if_dout       (if_dout),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .underrun_cnt  (underrun_cnt)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model
    logic [DW-1:0] mem [0:63];
    logic [5:0]    wr_ptr = '0;
    logic [5:0]    rd_ptr = '0;
    logic          fifo_en = 1'b1;
    logic          fifo_clr = 1'b0;

    assign if_empty_n = fifo_en && (wr_ptr != rd_ptr);
    assign if_dout    = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_clr) rd_ptr <= wr_ptr;
        else if (if_read) rd_ptr <= rd_ptr + 6'd1;
    end

    logic tog_en = 1'b0;
    always @(negedge clk) m_axis_tready = tog_en ? ~m_axis_tready : 1'b1;

    // Stream monitor
    logic          mon_clr = 1'b0;
    int            cyc = 0;
    int            npop, nb, nvalid, done_cnt, done_cyc, stab_err, max_ahead;
    int            pop_cyc [0:31];
    int            b_cyc   [0:31];
    logic [DW-1:0] b_data  [0:31];
    logic          b_user  [0:31];
    logic          b_last  [0:31];
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_user, prev_last;

    always @(posedge clk) begin
        if (mon_clr) begin
            npop = 0; nb = 0; nvalid = 0; done_cnt = 0; done_cyc = -1;
            stab_err = 0; max_ahead = 0; prev_stall = 1'b0;
        end else begin
            if (if_read) begin
                if (npop < 32) pop_cyc[npop] = cyc;
                npop++;
            end
            if (m_axis_tvalid) nvalid++;
            if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data ||
                               m_axis_tuser !== prev_user || m_axis_tlast !== prev_last))
                stab_err++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (nb < 32) begin
                    b_cyc[nb] = cyc; b_data[nb] = m_axis_tdata;
                    b_user[nb] = m_axis_tuser; b_last[nb] = m_axis_tlast;
                end
                nb++;
            end
            if (done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (npop - nb > max_ahead) max_ahead = npop - nb;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_user  = m_axis_tuser;
            prev_last  = m_axis_tlast;
        end
        cyc++;
    end

    int st_cyc;

    task automatic clear_all();
        @(negedge clk); mon_clr = 1'b1; fifo_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0; fifo_clr = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic start_frame(input int c, input int r);
        @(negedge clk); start = 1'b1; cols = MW'(c); rows = MW'(r);
        @(negedge clk); start = 1'b0; st_cyc = cyc - 1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_cnt != 0) break;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        mon_clr = 1'b0;
        checks++;
        if ({busy, done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, if_read} !== 6'b0 ||
            m_axis_tdata !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b tvalid=%b tuser=%b tlast=%b rd=%b data=%h, required all 0",
                     busy, done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, if_read, m_axis_tdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input logic toggle, input string name);
        clear_all();
        for (int i = 0; i < 8; i++) push_word(DW'(i));
        tog_en = toggle;
        start_frame(4, 2);
        wait_done(80, name);
        tog_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (npop != 8 || nb != 8) begin
            errors++;
            $display("FAIL %s_counts: pops=%0d beats=%0d, required 8/8", name, npop, nb);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (b_data[i] !== DW'(i) || b_user[i] !== (i == 0) || b_last[i] !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL %s_beat%0d: data=%h user=%b last=%b, required %h/%b/%b", name, i,
                         b_data[i], b_user[i], b_last[i], i, i == 0, i == 3 || i == 7);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != b_cyc[7] + 1) begin
            errors++;
            $display("FAIL %s_done: count=%0d at %0d, required 1 at %0d", name, done_cnt, done_cyc,
                     b_cyc[7] + 1);
        end
        if (!toggle) begin
            checks++;
            if (pop_cyc[0] != st_cyc + 1 || b_cyc[0] != pop_cyc[0] + 1 || b_cyc[7] != b_cyc[0] + 7) begin
                errors++;
                $display("FAIL %s_timing: pop0=%0d beat0=%0d beat7=%0d, required %0d/%0d/%0d", name,
                         pop_cyc[0], b_cyc[0], b_cyc[7], st_cyc + 1, st_cyc + 2, st_cyc + 9);
            end
        end else begin
            checks++;
            if (stab_err != 0 || max_ahead > 2) begin
                errors++;
                $display("FAIL %s_backpressure: unstable=%0d ahead=%0d, required 0 and <=2", name,
                         stab_err, max_ahead);
            end
        end
    endtask

    task automatic test_underrun();
        clear_all();
        fifo_en = 1'b0;
        for (int i = 0; i < 3; i++) push_word(DW'(100 + i));
        start_frame(3, 1);
        repeat (5) @(negedge clk);
        fifo_en = 1'b1;
        wait_done(40, "underrun");
        repeat (2) @(negedge clk);
        checks++;
        if (nb != 3 || b_data[0] !== 32'd100 || b_data[2] !== 32'd102 || b_user[0] !== 1'b1 ||
            b_last[1] !== 1'b0 || b_last[2] !== 1'b1) begin
            errors++;
            $display("FAIL underrun_beats: n=%0d d0=%h d2=%h u0=%b l1=%b l2=%b, required 3/64/66/1/0/1",
                     nb, b_data[0], b_data[2], b_user[0], b_last[1], b_last[2]);
        end
        checks++;
        if (underrun_cnt !== 32'(UndExp)) begin
            errors++;
            $display("FAIL underrun_cnt: got %0d, required %0d", underrun_cnt, UndExp);
        end
    endtask

    task automatic test_zero_dim();
        clear_all();
        push_word(32'hAA); push_word(32'hBB);
        start_frame(0, 5);
        wait_done(10, "zero");
        repeat (3) @(negedge clk);
        checks++;
        if (npop != 0 || nvalid != 0 || done_cnt != 1 || done_cyc != st_cyc + 1) begin
            errors++;
            $display("FAIL zero_dim: pops=%0d valids=%0d done=%0d at %0d, required 0/0/1 at %0d",
                     npop, nvalid, done_cnt, done_cyc, st_cyc + 1);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_all();
        for (int i = 0; i < 16; i++) push_word(DW'(200 + i));
        start_frame(4, 4);
        for (k = 0; k < 40 && nb < 6; k++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (if_read !== 1'b0) begin
            errors++;
            $display("FAIL midreset_read: if_read=%b during reset, required 0", if_read);
        end
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_tdata !== '0) begin
            errors++;
            $display("FAIL midreset_state: tvalid=%b busy=%b data=%h, required 0/0/0",
                     m_axis_tvalid, busy, m_axis_tdata);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL midreset_done: done count=%0d, required 0", done_cnt);
        end
        clear_all();
        push_word(32'd50); push_word(32'd51);
        start_frame(2, 1);
        wait_done(30, "after_reset");
        repeat (2) @(negedge clk);
        checks++;
        if (nb != 2 || b_data[0] !== 32'd50 || b_data[1] !== 32'd51 || b_user[0] !== 1'b1 ||
            b_user[1] !== 1'b0 || b_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_frame: n=%0d d=%h,%h u=%b,%b l1=%b, required 2 32,33 1,0 1",
                     nb, b_data[0], b_data[1], b_user[0], b_user[1], b_last[1]);
        end
    endtask

    task automatic test_restart_ignored();
        clear_all();
        for (int i = 0; i < 16; i++) push_word(DW'(300 + i));
        start_frame(3, 2);
        @(negedge clk);
        start = 1'b1; cols = MW'(5); rows = MW'(5);
        @(negedge clk);
        start = 1'b0;
        wait_done(40, "restart");
        repeat (3) @(negedge clk);
        checks++;
        if (npop != 6 || nb != 6 || done_cnt != 1 || b_last[2] !== 1'b1 || b_last[5] !== 1'b1 ||
            b_data[5] !== 32'd305) begin
            errors++;
            $display("FAIL restart_ignored: pops=%0d beats=%0d done=%0d l2=%b l5=%b d5=%0d, required 6/6/1/1/1/305",
                     npop, nb, done_cnt, b_last[2], b_last[5], b_data[5]);
        end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0, "basic");
        test_basic(1'b1, "toggle");
        test_underrun();
        test_zero_dim();
        test_reset_mid();
        test_restart_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pp_pipeline_accel_fifo_to_axis.md
Name: pp_pipeline_accel_fifo_to_axis

Overview:
- Consumer for the read side of the pipeline's shift-register ap_fifo channels; drains exactly rows x cols words and emits them as an AXI4-Stream video master.
- Generates TUSER (start of frame) and TLAST (end of line), with a 2-entry output buffer for 1 beat/cycle throughput under backpressure.
- Sits between the last accelerator FIFO and the output DMA / stream port.

Parameters:
- DATA_WIDTH, 32, width of FIFO word and m_axis_tdata.
- DIM_WIDTH, 16, width of cols/rows inputs and internal line/row counters.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
- cols  input  DIM_WIDTH  pixels per line; latched on accepted start.
- rows  input  DIM_WIDTH  lines per frame; latched on accepted start.
- busy  output  1  high in RUN or FLUSH.
- done  output  1  one-cycle pulse at frame completion.
- if_empty_n  input  1  FIFO has data; if_dout is valid in the same cycle (show-ahead).
- if_read  output  1  FIFO pop; the FIFO's read_ce is tied high outside this block.
- if_dout  input  DATA_WIDTH  FIFO head word.
- m_axis_tdata  output  DATA_WIDTH  stream data.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready.
- m_axis_tuser  output  1  high on first beat of frame.
- m_axis_tlast  output  1  high on last beat of each line.
- underrun_cnt  output  32  FIFO starvation cycle count (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at an edge): state IDLE; buffer emptied; counters cleared; busy=0, done=0, m_axis_tvalid=0, tdata/tuser/tlast=0. if_read is 0 combinationally in any cycle where reset_n=0.
- States:
  - IDLE: on start=1, latch cols/rows and clear col_cnt/row_cnt. If cols==0 or rows==0, go to DONE; otherwise go to RUN. start while busy is ignored.
  - RUN: if_read = if_empty_n & (buffer occupancy < 2, or one entry drains this cycle). A pop writes {if_dout, tuser=(col_cnt==0 && row_cnt==0), tlast=(col_cnt==cols-1)} into the buffer on the same edge. col_cnt wraps to 0 at cols-1 and row_cnt then increments. The pop of the last pixel (col_cnt==cols-1, row_cnt==rows-1) moves the state to FLUSH.
  - FLUSH: if_read=0; stay until the buffer is empty and the last beat is handshaken, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Buffer:
  - 2-entry FIFO; the head drives the m_axis_* outputs directly from registers.
  - A popped word is visible on tvalid one cycle after the pop edge.
  - With tready held high and the FIFO never empty, throughput is 1 beat/cycle.
  - Data/tuser/tlast hold stable while tvalid=1 and tready=0.
- Simultaneous push and drain at occupancy 2 is allowed: occupancy stays 2.
- No pop ever occurs beyond rows*cols words; surplus FIFO data stays in the FIFO.
- Reset mid-frame: in-flight buffer contents are discarded, no done pulse, the FIFO is untouched.

Optional Feature:
- Macro PP_FIFO2AXIS_UNDERRUN_CNT_EN.
- Defined: 32-bit counter, cleared on reset and on accepted start. Increments each cycle in RUN with if_empty_n=0 and buffer occupancy<2. Saturates at 0xFFFFFFFF. Drives underrun_cnt.
- Undefined: no counter logic; underrun_cnt tied to 0.

Test Plan:
- cols=4, rows=2, FIFO pre-filled with 0..7, tready=1 -> beats 0..7 in 8 consecutive cycles starting 1 cycle after the first pop; tuser only on beat 0; tlast on beats 3 and 7; done pulses the cycle after beat 7 handshakes; exactly 8 pops.
- Same frame with tready toggling 1,0,1,0 -> data order 0..7 unchanged; outputs stable during tready=0; at most 2 words popped ahead of the last accepted beat.
- cols=3, rows=1, if_empty_n low for 5 cycles after start then high with 3 words -> 3 beats, tlast on beat 2; with macro defined, underrun_cnt=5.
- start with cols=0, rows=5 -> no pops, no tvalid, done 2 cycles after start (IDLE->DONE->IDLE).
- cols=4, rows=4, reset_n low after 6 beats -> next cycle tvalid=0, busy=0, no done; a new start with cols=2, rows=1 gives 2 beats, tuser on the first.
- start pulsed again while busy with different cols -> ignored; the frame completes with the original dimensions.
